uart_cmd_responder: RTL and testbench
=====================================

UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 Parameter REG_COUNT, default 16, number of 32-bit registers in the local register file (1..256).
REQ-002 Parameter TX_TIMEOUT, default 2000000, CLK cycles to wait for TXSENT before aborting a response.
REQ-003 Port CLK, input, 1, single clock for all logic.
REQ-004 Port RST, input, 1; reset is asynchronous and active-low (RST=0 resets).
REQ-005 Port RXDATA_READY, input, 1, UART controller holds a received 128-bit packet.
REQ-006 Port RXDATA, input, 128, received request packet.
REQ-007 Port RXDATA_RETRIEVED, output, 1, one-cycle pulse: packet consumed.
REQ-008 Port TXDATA, output, 128, response packet; registered, stable from the EXEC edge until the next request.
REQ-009 Port TXCAPTURE, output, 1, one-cycle pulse: controller latches TXDATA.
REQ-010 Port TXTRANSMIT, output, 1, one-cycle pulse: controller starts serialising.
REQ-011 Port TXSENT, input, 1, controller finished sending; held high until TXACK.
REQ-012 Port TXACK, output, 1, one-cycle pulse acknowledging TXSENT.
REQ-013 Port BUSY, output, 1, high in every state except IDLE.
REQ-014 Port CMD_COUNT, output, 16, count of completed responses; wraps 0xFFFF->0x0000.
REQ-015 Port TIMEOUT_ERR, output, 1, sticky flag; set on TXSENT timeout, cleared only by reset.

Function
REQ-016 Request format: [127:120] opcode, [119:112] addr, [31:0] wdata; other bits ignored.
REQ-017 Opcodes: 0x01 WRITE (reg[addr]<=wdata), 0x02 READ, 0x03 ECHO; every other opcode is ILLEGAL.
REQ-018 Response format: [127:120] status, [119:112] addr, [111:104] opcode, [103:32] zero, [31:0] data.
REQ-019 Status 0x00 OK; 0xEE for an ILLEGAL opcode, or addr>=REG_COUNT on WRITE/READ; an error response carries data=0 and causes no register write.
REQ-020 Data field: WRITE returns wdata; READ returns reg[addr]; ECHO returns the response with request[119:0] copied into [119:0] and status 0x00.
REQ-021 FSM states: IDLE, EXEC, CAPT, XMIT, WAIT, ACK; all outputs are registered.
REQ-022 IDLE: on an edge with RXDATA_READY=1, latch RXDATA, set RXDATA_RETRIEVED=1, go to EXEC; otherwise remain in IDLE.
REQ-023 EXEC: RXDATA_RETRIEVED=0, perform the register write if applicable, load TXDATA, go to CAPT.
REQ-024 CAPT: TXCAPTURE=1, go to XMIT.
REQ-025 XMIT: TXCAPTURE=0, TXTRANSMIT=1, clear the timeout counter, go to WAIT.
REQ-026 WAIT: TXTRANSMIT=0; if TXSENT=1, set TXACK=1, increment CMD_COUNT, go to ACK; otherwise increment the timeout counter.
REQ-027 WAIT timeout: when the counter reaches TX_TIMEOUT-1 without TXSENT, set TIMEOUT_ERR, go to IDLE, leave CMD_COUNT unchanged.
REQ-028 ACK: TXACK=0, go to IDLE; RXDATA_READY is ignored in every state except IDLE.
REQ-029 Latency: RXDATA_READY sampled -> TXCAPTURE high is 3 edges; TXSENT sampled -> TXACK high is 1 edge.
REQ-030 TXSENT already high on WAIT entry is accepted on the first WAIT edge.
REQ-031 A READ of an address written by the immediately preceding request returns the new value.

Reset
REQ-032 RST=0 asynchronously forces IDLE, zeroes all registers, TXDATA and CMD_COUNT, and drives RXDATA_RETRIEVED, TXCAPTURE, TXTRANSMIT, TXACK, BUSY and TIMEOUT_ERR low.
REQ-033 Reset asserted mid-transaction aborts it; after release, no pulse resumes and the aborted request is not counted.

Verification
REQ-034 WRITE 0x01/addr 0x03/wdata 0xDEADBEEF, then READ 0x02/addr 0x03 -> second response 0x00,0x03,0x02,...,0xDEADBEEF; CMD_COUNT=2.
REQ-035 Opcode 0x7F -> status 0xEE, data 0, no register changed; addr 0x10 READ with REG_COUNT=16 -> status 0xEE.
REQ-036 ECHO with RXDATA=128'h03AB...1234 -> TXDATA[119:0] equal to the request, [127:120]=0x00.
REQ-037 Handshake timing: RXDATA_RETRIEVED, TXCAPTURE, TXTRANSMIT each exactly 1 cycle on consecutive edges; TXACK 1 cycle after TXSENT rises.
REQ-038 TX_TIMEOUT=8, TXSENT held 0 -> TIMEOUT_ERR=1 after 8 WAIT cycles, BUSY=0, CMD_COUNT unchanged.
REQ-039 RST=0 pulsed in WAIT -> all outputs 0 immediately; the next request is served normally.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// UART command responder: executes WRITE/READ/ECHO requests on a local
// register file and runs the response handshake with the UART controller.
// Ports:
//   CLK, RST (async active-low)
//   RXDATA_READY, RXDATA[127:0]  -> request in
//   RXDATA_RETRIEVED             <- request consumed pulse
//   TXDATA[127:0], TXCAPTURE, TXTRANSMIT, TXACK <- response handshake
//   TXSENT                       -> controller finished sending
//   BUSY, CMD_COUNT[15:0], TIMEOUT_ERR <- status
module uart_cmd_responder #(
   parameter int REG_COUNT  = 16,
   parameter int TX_TIMEOUT = 2000000
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         RXDATA_READY,
   input  logic [127:0] RXDATA,
   output logic         RXDATA_RETRIEVED,
   output logic [127:0] TXDATA,
   output logic         TXCAPTURE,
   output logic         TXTRANSMIT,
   input  logic         TXSENT,
   output logic         TXACK,
   output logic         BUSY,
   output logic [15:0]  CMD_COUNT,
   output logic         TIMEOUT_ERR
);

   localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
   localparam logic [31:0] TLIM = 32'(TX_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_EXEC, S_CAPT, S_XMIT, S_WAIT, S_ACK
   } state_t;

   state_t state, state_nx;

   logic [127:0] req, req_nx, txd_nx, resp;
   logic [31:0]  regs [REG_COUNT];
   logic [31:0]  timer, timer_nx;
   logic [15:0]  cnt_nx;
   logic         retr_nx, capt_nx, xmit_nx, ack_nx;
   logic         busy_nx, err_nx, we;

   logic [7:0]    op, addr;
   logic [31:0]   wdata;
   logic [AW-1:0] idx;
   logic          addr_ok, is_wr, is_rd, is_echo;

   assign op      = req[127:120];
   assign addr    = req[119:112];
   assign wdata   = req[31:0];
   assign idx     = addr[AW-1:0];
   assign addr_ok = {1'b0, addr} < 9'(REG_COUNT);
   assign is_wr   = (op == 8'h01) && addr_ok;
   assign is_rd   = (op == 8'h02) && addr_ok;
   assign is_echo = (op == 8'h03);

   // Error response (illegal opcode or bad address) is the default.
   always_comb begin
      resp = {8'hEE, addr, op, 72'h0, 32'h0};
      unique case (1'b1)
         is_echo: resp = {8'h00, req[119:0]};
         is_wr:   resp = {8'h00, addr, op, 72'h0, wdata};
         is_rd:   resp = {8'h00, addr, op, 72'h0, regs[idx]};
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= S_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: if (RXDATA_READY) state_nx = S_EXEC;
         S_EXEC: state_nx = S_CAPT;
         S_CAPT: state_nx = S_XMIT;
         S_XMIT: state_nx = S_WAIT;
         S_WAIT: begin
            if (TXSENT)             state_nx = S_ACK;
            else if (timer == TLIM) state_nx = S_IDLE;
         end
         S_ACK:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Next values for every registered output; pulses default low.
   always_comb begin
      req_nx   = req;
      txd_nx   = TXDATA;
      timer_nx = timer;
      cnt_nx   = CMD_COUNT;
      err_nx   = TIMEOUT_ERR;
      retr_nx  = 1'b0;
      capt_nx  = 1'b0;
      xmit_nx  = 1'b0;
      ack_nx   = 1'b0;
      we       = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (RXDATA_READY) begin
               req_nx  = RXDATA;
               retr_nx = 1'b1;
            end
         end
         S_EXEC: begin
            we     = is_wr;
            txd_nx = resp;
         end
         S_CAPT: capt_nx = 1'b1;
         S_XMIT: begin
            xmit_nx  = 1'b1;
            timer_nx = '0;
         end
         S_WAIT: begin
            if (TXSENT) begin
               ack_nx = 1'b1;
               cnt_nx = CMD_COUNT + 16'd1;
            end else if (timer == TLIM) begin
               err_nx = 1'b1;
            end else begin
               timer_nx = timer + 32'd1;
            end
         end
         default: ;
      endcase
      busy_nx = (state_nx != S_IDLE);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         req              <= '0;
         TXDATA           <= '0;
         timer            <= '0;
         CMD_COUNT        <= '0;
         TIMEOUT_ERR      <= 1'b0;
         RXDATA_RETRIEVED <= 1'b0;
         TXCAPTURE        <= 1'b0;
         TXTRANSMIT       <= 1'b0;
         TXACK            <= 1'b0;
         BUSY             <= 1'b0;
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else begin
         req              <= req_nx;
         TXDATA           <= txd_nx;
         timer            <= timer_nx;
         CMD_COUNT        <= cnt_nx;
         TIMEOUT_ERR      <= err_nx;
         RXDATA_RETRIEVED <= retr_nx;
         TXCAPTURE        <= capt_nx;
         TXTRANSMIT       <= xmit_nx;
         TXACK            <= ack_nx;
         BUSY             <= busy_nx;
         if (we) regs[idx] <= wdata;
      end
   end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: register ops, errors, echo,
// handshake timing, TXSENT timeout and mid-transaction reset.
module tb_uart_cmd_responder;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         RXDATA_READY = 1'b0;
   logic [127:0] RXDATA = '0;
   logic         RXDATA_RETRIEVED;
   logic [127:0] TXDATA;
   logic         TXCAPTURE;
   logic         TXTRANSMIT;
   logic         TXSENT = 1'b0;
   logic         TXACK;
   logic         BUSY;
   logic [15:0]  CMD_COUNT;
   logic         TIMEOUT_ERR;

   int total = 0;
   int bad   = 0;

   uart_cmd_responder #(.REG_COUNT(16), .TX_TIMEOUT(8)) dut (
      .CLK(CLK), .RST(RST),
      .RXDATA_READY(RXDATA_READY), .RXDATA(RXDATA),
      .RXDATA_RETRIEVED(RXDATA_RETRIEVED),
      .TXDATA(TXDATA), .TXCAPTURE(TXCAPTURE),
      .TXTRANSMIT(TXTRANSMIT), .TXSENT(TXSENT), .TXACK(TXACK),
      .BUSY(BUSY), .CMD_COUNT(CMD_COUNT), .TIMEOUT_ERR(TIMEOUT_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] mk(input logic [7:0] op,
      input logic [7:0] a, input logic [31:0] d);
      return {op, a, 80'h0, d};
   endfunction

   function automatic logic [127:0] rsp(input logic [7:0] st,
      input logic [7:0] a, input logic [7:0] op, input logic [31:0] d);
      return {st, a, op, 72'h0, d};
   endfunction

   // Drive a request and walk it to WAIT, checking each pulse edge.
   task automatic start(input logic [127:0] r, input logic [127:0] exp);
      @(negedge CLK);
      RXDATA = r;
      RXDATA_READY = 1'b1;
      @(negedge CLK);
      RXDATA_READY = 1'b0;
      chk("retrieved_hi", 128'(RXDATA_RETRIEVED), 128'(1));
      chk("busy_hi", 128'(BUSY), 128'(1));
      @(negedge CLK);
      chk("retrieved_lo", 128'(RXDATA_RETRIEVED), 128'(0));
      chk("txdata", TXDATA, exp);
      chk("capture_pre", 128'(TXCAPTURE), 128'(0));
      @(negedge CLK);
      chk("capture_hi", 128'(TXCAPTURE), 128'(1));
      @(negedge CLK);
      chk("capture_lo", 128'(TXCAPTURE), 128'(0));
      chk("transmit_hi", 128'(TXTRANSMIT), 128'(1));
   endtask

   // Answer TXSENT immediately on WAIT entry and close the handshake.
   task automatic finish(input logic [15:0] cnt);
      TXSENT = 1'b1;
      @(negedge CLK);
      chk("transmit_lo", 128'(TXTRANSMIT), 128'(0));
      chk("ack_hi", 128'(TXACK), 128'(1));
      chk("count", 128'(CMD_COUNT), 128'(cnt));
      TXSENT = 1'b0;
      @(negedge CLK);
      chk("ack_lo", 128'(TXACK), 128'(0));
      chk("busy_lo", 128'(BUSY), 128'(0));
   endtask

   initial begin
      logic [127:0] echo_req;
      echo_req = 128'h03AB_0000_1111_2222_3333_4444_5555_1234;

      #12;
      chk("rst_txdata", TXDATA, 128'h0);
      chk("rst_count", 128'(CMD_COUNT), 128'h0);
      chk("rst_busy", 128'(BUSY), 128'h0);
      chk("rst_err", 128'(TIMEOUT_ERR), 128'h0);
      RST = 1'b1;

      start(mk(8'h01, 8'h03, 32'hDEADBEEF),
            rsp(8'h00, 8'h03, 8'h01, 32'hDEADBEEF));
      finish(16'd1);
      start(mk(8'h02, 8'h03, 32'h0),
            rsp(8'h00, 8'h03, 8'h02, 32'hDEADBEEF));
      finish(16'd2);

      start(mk(8'h7F, 8'h03, 32'h12345678),
            rsp(8'hEE, 8'h03, 8'h7F, 32'h0));
      finish(16'd3);
      start(mk(8'h02, 8'h03, 32'h0),
            rsp(8'h00, 8'h03, 8'h02, 32'hDEADBEEF));
      finish(16'd4);

      start(mk(8'h02, 8'h10, 32'h0),
            rsp(8'hEE, 8'h10, 8'h02, 32'h0));
      finish(16'd5);
      start(mk(8'h01, 8'h10, 32'h55),
            rsp(8'hEE, 8'h10, 8'h01, 32'h0));
      finish(16'd6);
      start(mk(8'h01, 8'h0F, 32'hA5A5A5A5),
            rsp(8'h00, 8'h0F, 8'h01, 32'hA5A5A5A5));
      finish(16'd7);
      start(mk(8'h02, 8'h0F, 32'h0),
            rsp(8'h00, 8'h0F, 8'h02, 32'hA5A5A5A5));
      finish(16'd8);
      start(mk(8'h02, 8'h00, 32'h0),
            rsp(8'h00, 8'h00, 8'h02, 32'h0));
      finish(16'd9);

      start(echo_req, 128'h00AB_0000_1111_2222_3333_4444_5555_1234);
      finish(16'd10);

      // TXSENT never arrives: 8 WAIT edges then abort.
      start(mk(8'h02, 8'h03, 32'h0),
            rsp(8'h00, 8'h03, 8'h02, 32'hDEADBEEF));
      repeat (7) @(negedge CLK);
      chk("to_err_early", 128'(TIMEOUT_ERR), 128'(0));
      chk("to_busy_early", 128'(BUSY), 128'(1));
      @(negedge CLK);
      chk("to_err", 128'(TIMEOUT_ERR), 128'(1));
      chk("to_busy", 128'(BUSY), 128'(0));
      chk("to_count", 128'(CMD_COUNT), 128'd10);
      chk("to_ack", 128'(TXACK), 128'(0));

      start(mk(8'h02, 8'h03, 32'h0),
            rsp(8'h00, 8'h03, 8'h02, 32'hDEADBEEF));
      finish(16'd11);
      chk("err_sticky", 128'(TIMEOUT_ERR), 128'(1));

      // Reset while waiting for TXSENT.
      start(mk(8'h01, 8'h05, 32'h77),
            rsp(8'h00, 8'h05, 8'h01, 32'h77));
      RST = 1'b0;
      #1;
      chk("mr_txdata", TXDATA, 128'h0);
      chk("mr_count", 128'(CMD_COUNT), 128'h0);
      chk("mr_err", 128'(TIMEOUT_ERR), 128'h0);
      chk("mr_busy", 128'(BUSY), 128'h0);
      chk("mr_xmit", 128'(TXTRANSMIT), 128'h0);
      #1 RST = 1'b1;
      repeat (3) @(negedge CLK);
      chk("mr_idle_busy", 128'(BUSY), 128'h0);
      chk("mr_no_capt", 128'(TXCAPTURE), 128'h0);
      chk("mr_no_ack", 128'(TXACK), 128'h0);

      start(mk(8'h02, 8'h03, 32'h0),
            rsp(8'h00, 8'h03, 8'h02, 32'h0));
      finish(16'd1);
      start(mk(8'h02, 8'h05, 32'h0),
            rsp(8'h00, 8'h05, 8'h02, 32'h0));
      finish(16'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
